// File: rtl/mmio_uart_tx_pkg.sv
// -----------------------------------------------------------------------------
// mmio_uart_tx_pkg
// Shared definitions for the memory-mapped UART transmitter:
//   - CPU data-path width
//   - STATUS word bit positions
//   - serializer FSM state encodings
//   - register offsets relative to BASE_ADDR (TXDATA, STATUS)
//   - even-parity helper used by the optional parity bit
// -----------------------------------------------------------------------------
package mmio_uart_tx_pkg;

    localparam int DATA_W = 32;

    // STATUS word bit positions
    localparam int STAT_BUSY  = 0;
    localparam int STAT_EMPTY = 1;
    localparam int STAT_FULL  = 2;
    localparam int STAT_OVF   = 3;
    localparam int STAT_PAR   = 4;

    // Serializer FSM encodings
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // Register offsets from BASE_ADDR
    localparam logic [DATA_W-1:0] OFF_TXDATA = 32'h0000_0000;
    localparam logic [DATA_W-1:0] OFF_STATUS = 32'h0000_0004;

    // Even parity: XOR of all data bits
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// mmio_uart_tx_fifo (tx_fifo)
// Synchronous byte FIFO feeding the UART serializer.
// A push while full is accepted only when a pop happens on the same edge;
// otherwise it is ignored (the caller tracks overflow).
// Ports:
//   clk_i    system clock
//   rst_i    synchronous active-high reset, flushes the FIFO
//   push_i   push request, data_i[7:0] is written
//   pop_i    pop request, data_o is the head before the edge
//   data_o   head-of-queue byte
//   full_o   count == DEPTH
//   empty_o  count == 0
//   count_o  number of stored bytes (log2(DEPTH)+1 bits)
// -----------------------------------------------------------------------------
module mmio_uart_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [7:0]               data_i,
    input  logic                     pop_i,
    output logic [7:0]               data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] wr_ptr_d;
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] rd_ptr_d;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == {CW{1'b0}});
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // Accept/refuse decisions and next-state pointers and count
    always_comb begin
        pop_ok_s  = pop_i & ~empty_o;
        // Full FIFO still takes a byte when the head leaves on the same edge
        push_ok_s = push_i & (~full_o | pop_ok_s);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Byte storage; contents need no reset because the pointers define validity
    always_ff @(posedge clk_i) begin
        if (!rst_i && push_ok_s) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// -----------------------------------------------------------------------------
// mmio_uart_tx
// Memory-mapped UART transmitter on the CPU data-store interface.
// Stores to BASE_ADDR (TXDATA) queue wd[7:0]; the serializer sends each byte
// as an 8N1 frame (start, 8 data bits LSB first, stop) on txd.
// STATUS at BASE_ADDR+4: bit0 busy, bit1 empty, bit2 full, bit3 overflow
// (sticky, cleared by storing wd[3]=1 to STATUS), bit4 parity enabled.
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit between
// the data bits and the stop bit (11-bit frame) and sets STATUS bit4.
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset
//   addr  CPU data address
//   wd    CPU store data
//   we    CPU store strobe
//   rd    STATUS word when hit=1, otherwise 0 (combinational)
//   hit   address matches TXDATA or STATUS (combinational)
//   txd   serial output, idles high (registered)
// -----------------------------------------------------------------------------
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter logic [DATA_W-1:0] BASE_ADDR    = 32'h0000_7ff0,
    parameter int                CLKS_PER_BIT = 4,
    parameter int                FIFO_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] wd,
    input  logic              we,
    output logic [DATA_W-1:0] rd,
    output logic              hit,
    output logic              txd
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int FCW   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic              txdata_sel_s;
    logic              status_sel_s;
    logic              push_s;
    logic              pop_s;
    logic [7:0]        fifo_data_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [FCW-1:0]    fifo_count_s;
    logic              baud_last_s;
    logic [DATA_W-1:0] status_s;
    logic              unused_wd_s;

    logic [2:0]        state_q;
    logic [2:0]        state_d;
    logic [CNT_W-1:0]  baud_q;
    logic [CNT_W-1:0]  baud_d;
    logic [2:0]        bit_q;
    logic [2:0]        bit_d;
    logic [7:0]        shift_q;
    logic [7:0]        shift_d;
    logic              txd_q;
    logic              txd_d;
    logic              ovf_q;
    logic              ovf_d;

    assign txdata_sel_s = (addr == (BASE_ADDR + OFF_TXDATA));
    assign status_sel_s = (addr == (BASE_ADDR + OFF_STATUS));
    assign push_s       = we & txdata_sel_s;
    assign baud_last_s  = (baud_q == BAUD_LAST);
    assign unused_wd_s  = ^wd[DATA_W-1:8];

    mmio_uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (push_s),
        .data_i  (wd[7:0]),
        .pop_i   (pop_s),
        .data_o  (fifo_data_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_s)
    );

    // STATUS word and read/decode outputs
    always_comb begin
        status_s             = {DATA_W{1'b0}};
        status_s[STAT_BUSY]  = (state_q != ST_IDLE) | (fifo_count_s != {FCW{1'b0}});
        status_s[STAT_EMPTY] = fifo_empty_s;
        status_s[STAT_FULL]  = fifo_full_s;
        status_s[STAT_OVF]   = ovf_q;
`ifdef UART_TX_PARITY_EN
        status_s[STAT_PAR]   = 1'b1;
`else
        status_s[STAT_PAR]   = 1'b0;
`endif
        hit = txdata_sel_s | status_sel_s;
        if (hit) begin
            rd = status_s;
        end else begin
            rd = {DATA_W{1'b0}};
        end
    end

    // Sticky overflow: set on a refused push, cleared by STATUS write of bit3
    always_comb begin
        if (push_s && fifo_full_s && !pop_s) begin
            ovf_d = 1'b1;
        end else if (we && status_sel_s && wd[STAT_OVF]) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Serializer next state; txd_d is the line value for the coming bit period
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        pop_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s   = 1'b1;
                    shift_d = fifo_data_s;
                    baud_d  = {CNT_W{1'b0}};
                    state_d = ST_START;
                    txd_d   = 1'b0;
                end else begin
                    txd_d   = 1'b1;
                end
            end
            ST_START: begin
                if (baud_last_s) begin
                    baud_d  = {CNT_W{1'b0}};
                    bit_d   = 3'd0;
                    state_d = ST_DATA;
                    txd_d   = shift_q[0];
                end else begin
                    baud_d  = baud_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    txd_d   = 1'b0;
                end
            end
            ST_DATA: begin
                if (baud_last_s) begin
                    baud_d = {CNT_W{1'b0}};
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
                        txd_d   = even_parity(shift_q);
`else
                        state_d = ST_STOP;
                        txd_d   = 1'b1;
`endif
                    end else begin
                        // Shift register is indexed rather than shifted so the
                        // whole byte is still available for the parity bit
                        bit_d = bit_q + 3'd1;
                        txd_d = shift_q[bit_q + 3'd1];
                    end
                end else begin
                    baud_d = baud_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    txd_d  = shift_q[bit_q];
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_last_s) begin
                    baud_d  = {CNT_W{1'b0}};
                    state_d = ST_STOP;
                    txd_d   = 1'b1;
                end else begin
                    baud_d  = baud_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    txd_d   = even_parity(shift_q);
                end
            end
`endif
            ST_STOP: begin
                if (baud_last_s) begin
                    baud_d = {CNT_W{1'b0}};
                    // Chain straight into the next start bit when data waits
                    if (!fifo_empty_s) begin
                        pop_s   = 1'b1;
                        shift_d = fifo_data_s;
                        state_d = ST_START;
                        txd_d   = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        txd_d   = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    txd_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                baud_d  = {CNT_W{1'b0}};
                bit_d   = 3'd0;
                txd_d   = 1'b1;
            end
        endcase
    end

    // Serializer and overflow registers; reset abandons any frame in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            baud_q  <= {CNT_W{1'b0}};
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            txd_q   <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            ovf_q   <= ovf_d;
        end
    end

    assign txd = txd_q;

endmodule
